// File: rtl/dcs_pkg.sv
// Shared types and width helpers for the Gram/threshold/weight MAC block.
package dcs_pkg;

  typedef enum logic [2:0] {LOAD, GRAM, AVG, WGT, OUT} state_e;

  // Counter width that stays at least one bit wide for degenerate sizes.
  function automatic int cw(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

  // Width of a Gram entry: a sum of D products of two DW-bit values.
  function automatic int gram_w(input int dw, input int d);
    return 2 * dw + $clog2(d);
  endfunction

  // Width of a Gram row sum over N entries.
  function automatic int sum_w(input int dw, input int d, input int n);
    return gram_w(dw, d) + $clog2(n);
  endfunction

  // Width of a weighted accumulator: N products of a Gram entry and a weight.
  function automatic int acc_w(input int dw, input int d, input int ww, input int n);
    return gram_w(dw, d) + ww + $clog2(n);
  endfunction

endpackage

// File: rtl/dcs_gram_mac_if.sv
// Input, weight and result streams of the Gram MAC, plus the mask enable.
interface dcs_gram_mac_if #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int OW = 32
);
  logic          mask_en;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          w_valid;
  logic          w_ready;
  logic [WW-1:0] w_data;
  logic          o_valid;
  logic          o_ready;
  logic [OW-1:0] o_data;
  logic          o_last;

  modport master (
    output mask_en, i_valid, i_data, w_valid, w_data, o_ready,
    input  i_ready, w_ready, o_valid, o_data, o_last
  );

  modport slave (
    input  mask_en, i_valid, i_data, w_valid, w_data, o_ready,
    output i_ready, w_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/dcs_mac_lane.sv
// One multiply-accumulate lane; operands come from the Gram or weight phase.
module dcs_mac_lane #(
  parameter int AW  = 20,  // operand A width (Gram entry)
  parameter int BW  = 8,   // operand B width (X element or weight)
  parameter int ACW = 31,  // accumulator width
  parameter int GOW = 20   // width of the Gram result tapped from the sum
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           sel_wgt,
  input  logic [AW-1:0]  gram_a,
  input  logic [BW-1:0]  gram_b,
  input  logic [AW-1:0]  wgt_a,
  input  logic [BW-1:0]  wgt_b,
  output logic [ACW-1:0] acc_o,
  output logic [GOW-1:0] gram_o
);
  logic [AW-1:0]    op_a;
  logic [BW-1:0]    op_b;
  logic [AW+BW-1:0] prod;
  logic [ACW-1:0]   sum;
  logic [ACW-1:0]   acc_q, acc_d;

  // Operand select, product, running sum and next accumulator value.
  always_comb begin
    op_a  = sel_wgt ? wgt_a : gram_a;
    op_b  = sel_wgt ? wgt_b : gram_b;
    prod  = op_a * op_b;
    sum   = acc_q + ACW'(prod);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o  = acc_q;
  assign gram_o = GOW'(sum);
endmodule

// File: rtl/dcs_gram_mac.sv
// Gram matrix X*X^T, optional row-mean threshold, then K weight columns.
module dcs_gram_mac
  import dcs_pkg::*;
#(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int K  = 1,
  parameter int OW = 32
) (
  input logic           clk,
  input logic           rst_n,
  dcs_gram_mac_if.slave bus
);
  localparam int GW  = gram_w(DW, D);
  localparam int SW  = sum_w(DW, D, N);
  localparam int ACW = acc_w(DW, D, WW, N);
  localparam int BW  = (DW > WW) ? DW : WW;
  localparam int LN  = $clog2(N);
  localparam int RW  = cw(N);
  localparam int FW  = cw(D);
  localparam int CW  = cw(K);

  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;      // row / weight index / output index
  logic [FW-1:0]   k_q, k_d;      // feature index
  logic [CW-1:0]   col_q, col_d;  // weight column
  logic            mask_q, mask_d;
  logic            o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [OW-1:0]   o_data_q, o_data_d;
  logic [DW-1:0]   x_q [N][D];
  logic [DW-1:0]   x_d [N][D];
  logic [GW-1:0]   g_q [N][N];
  logic [GW-1:0]   g_d [N][N];
  logic [SW-1:0]   rs_q [N];
  logic [SW-1:0]   rs_d [N];
  logic            lane_clr, lane_en, sel_wgt;
  logic [ACW-1:0]  lane_acc [N];
  logic [GW-1:0]   lane_gram [N];
  logic            i_fire, w_fire, r_last, k_last, col_last;

  assign bus.i_ready = (state_q == LOAD);
  assign bus.w_ready = (state_q == WGT);
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_last  = o_last_q;

  assign i_fire   = bus.i_valid && (state_q == LOAD);
  assign w_fire   = bus.w_valid && (state_q == WGT);
  assign r_last   = (r_q == RW'(N - 1));
  assign k_last   = (k_q == FW'(D - 1));
  assign col_last = (col_q == CW'(K - 1));
  assign sel_wgt  = (state_q == WGT);

  // Lane gi owns column gi of G while building it, and row gi of y while weighting.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      dcs_mac_lane #(.AW(GW), .BW(BW), .ACW(ACW), .GOW(GW)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (lane_clr),
        .en     (lane_en),
        .sel_wgt(sel_wgt),
        .gram_a (GW'(x_q[r_q][k_q])),
        .gram_b (BW'(x_q[gi][k_q])),
        .wgt_a  (g_q[gi][r_q]),
        .wgt_b  (BW'(bus.w_data)),
        .acc_o  (lane_acc[gi]),
        .gram_o (lane_gram[gi])
      );
    end
  endgenerate

  // Next-state, buffer updates and lane control for the whole matrix flow.
  always_comb begin : p_next
    logic [SW-1:0] rsum;
    logic [SW-1:0] avg;
    logic [RW-1:0] r_nx;
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    col_d     = col_q;
    mask_d    = mask_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    x_d       = x_q;
    g_d       = g_q;
    rs_d      = rs_q;
    lane_clr  = 1'b0;
    lane_en   = 1'b0;
    rsum      = '0;
    avg       = '0;
    r_nx      = r_q + 1'b1;
    unique case (state_q)
      LOAD: begin
        if (i_fire) begin
          x_d[r_q][k_q] = bus.i_data;
          if (r_q == '0 && k_q == '0) mask_d = bus.mask_en;
          if (k_last) begin
            k_d = '0;
            r_d = r_nx;
            if (r_last) state_d = GRAM;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      GRAM: begin
        lane_en = 1'b1;
        if (k_last) begin
          // Row r_q of G completes this cycle; capture it and restart the lanes.
          lane_clr = 1'b1;
          k_d      = '0;
          for (int c = 0; c < N; c++) begin
            g_d[r_q][c] = lane_gram[c];
            rsum        = rsum + SW'(lane_gram[c]);
          end
          rs_d[r_q] = rsum;
          r_d       = r_nx;
          if (r_last) state_d = AVG;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      AVG: begin
        for (int r = 0; r < N; r++) begin
          avg = rs_q[r] >> LN;
          for (int c = 0; c < N; c++) begin
            if (mask_q && (SW'(g_q[r][c]) < avg)) g_d[r][c] = '0;
          end
        end
        r_d     = '0;
        state_d = WGT;
      end
      WGT: begin
        if (w_fire) begin
          lane_en = 1'b1;
          r_d     = r_nx;
          if (r_last) state_d = OUT;
        end
      end
      OUT: begin
        if (!o_valid_q) begin
          o_valid_d = 1'b1;
          o_data_d  = OW'(lane_acc[r_q]);
          o_last_d  = r_last && col_last;
        end else if (bus.o_ready) begin
          if (r_last) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
            lane_clr  = 1'b1;
            r_d       = '0;
            if (col_last) begin
              col_d   = '0;
              k_d     = '0;
              g_d     = '{default: '0};
              rs_d    = '{default: '0};
              state_d = LOAD;
            end else begin
              col_d   = col_q + 1'b1;
              state_d = WGT;
            end
          end else begin
            r_d      = r_nx;
            o_data_d = OW'(lane_acc[r_nx]);
            o_last_d = (r_nx == RW'(N - 1)) && col_last;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State, counters, buffers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      r_q       <= '0;
      k_q       <= '0;
      col_q     <= '0;
      mask_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      x_q       <= '{default: '0};
      g_q       <= '{default: '0};
      rs_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      k_q       <= k_d;
      col_q     <= col_d;
      mask_q    <= mask_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_data_q  <= o_data_d;
      x_q       <= x_d;
      g_q       <= g_d;
      rs_q      <= rs_d;
    end
  end
endmodule
